// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, controller state encoding and block-align helper for the cache controller.
package cache_pkg;
    localparam int PA_WIDTH = 32;
    localparam int OFFSET_WIDTH = 4;
    localparam int BLK_WIDTH = PA_WIDTH - OFFSET_WIDTH;
    localparam int LAT_WIDTH = 4;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL, RESP} cache_state_t;

    function automatic logic [PA_WIDTH-1:0] blk_align(input logic [PA_WIDTH-1:0] a);
        return a & {{BLK_WIDTH{1'b1}}, {OFFSET_WIDTH{1'b0}}};
    endfunction
endpackage

// File: rtl/cache_ctrl_mem_lat_cnt.sv
// mem_lat_cnt: loadable down-counter with zero flag, timing both memory phases.
module mem_lat_cnt
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LAT_WIDTH-1:0] load_val,
    output logic                 zero
);
    logic [LAT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!zero) cnt <= cnt - LAT_WIDTH'(1);
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing FSM for a direct-mapped write-back write-allocate cache.
// Define CACHE_STATS_EN to add saturating hit/miss/writeback counters.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_LAT = 4
`ifdef CACHE_STATS_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    input  logic                cpu_req_rw,
    input  logic [PA_WIDTH-1:0] cpu_req_addr,
    output logic                cpu_req_ready,
    output logic                cpu_resp_valid,
    output logic [PA_WIDTH-1:0] arr_addr,
    output logic                arr_lookup,
    input  logic                tag_hit,
    input  logic                victim_dirty,
    input  logic [PA_WIDTH-1:0] victim_tag_addr,
    output logic                arr_rd_en,
    output logic                arr_wr_en,
    output logic                arr_fill_en,
    output logic [PA_WIDTH-1:0] mem_addr,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic                busy
`ifdef CACHE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_hits,
    output logic [CNT_WIDTH-1:0] stat_misses,
    output logic [CNT_WIDTH-1:0] stat_writebacks
`endif
);
    cache_state_t state, next_state;
    logic [PA_WIDTH-1:0] addr_q;
    logic rw_q, lat_zero, lat_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr_q <= '0;
            rw_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && cpu_req_valid) begin
                addr_q <= cpu_req_addr;
                rw_q <= cpu_req_rw;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      next_state = cpu_req_valid ? COMPARE : IDLE;
            COMPARE:   next_state = tag_hit ? RESP : victim_dirty ? WRITEBACK : ALLOCATE;
            WRITEBACK: next_state = lat_zero ? ALLOCATE : WRITEBACK;
            ALLOCATE:  next_state = lat_zero ? FILL : ALLOCATE;
            FILL:      next_state = COMPARE;
            RESP:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Reload on entry to either memory phase so each lasts exactly MEM_LAT cycles.
    assign lat_load = next_state != state && (next_state == WRITEBACK || next_state == ALLOCATE);

    mem_lat_cnt u_lat (
        .clk(clk),
        .rst(rst),
        .load(lat_load),
        .load_val(LAT_WIDTH'(MEM_LAT - 1)),
        .zero(lat_zero)
    );

    assign cpu_req_ready = state == IDLE;
    assign cpu_resp_valid = state == RESP;
    assign busy = state != IDLE;
    assign arr_addr = addr_q;
    assign arr_lookup = state == COMPARE;
    assign arr_rd_en = state == COMPARE && tag_hit && !rw_q;
    assign arr_wr_en = state == COMPARE && tag_hit && rw_q;
    assign arr_fill_en = state == FILL;
    assign mem_wr_en = state == WRITEBACK;
    assign mem_rd_en = state == ALLOCATE;
    assign mem_addr = state == WRITEBACK ? blk_align(victim_tag_addr) :
                      state == ALLOCATE  ? blk_align(addr_q) : '0;

`ifdef CACHE_STATS_EN
    logic refill_q, first_cmp;

    // The COMPARE after a fill always hits and belongs to the same request.
    assign first_cmp = state == COMPARE && !refill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            refill_q <= 1'b0;
            stat_hits <= '0;
            stat_misses <= '0;
            stat_writebacks <= '0;
        end else begin
            if (state == FILL) refill_q <= 1'b1;
            else if (state == IDLE) refill_q <= 1'b0;
            if (first_cmp && tag_hit && !(&stat_hits)) stat_hits <= stat_hits + CNT_WIDTH'(1);
            if (first_cmp && !tag_hit && !(&stat_misses)) stat_misses <= stat_misses + CNT_WIDTH'(1);
            if (first_cmp && !tag_hit && victim_dirty && !(&stat_writebacks))
                stat_writebacks <= stat_writebacks + CNT_WIDTH'(1);
        end
    end
`endif
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing FSM for a direct-mapped, write-back, write-allocate cache.
- Sits between the CPU request interface, the cache_data array (tag/valid/dirty compare plus data storage) and the mem block.
- Accepts one CPU read or write at a time. Issues the array lookup, evicts a dirty victim to mem, refills the block from mem, then retires the request.
- Memory has a fixed, parameterised access latency, which the controller counts.

Parameters:
- PA_WIDTH, 32: physical address width.
- OFFSET_WIDTH, 4: block offset bits; block address = addr with the low OFFSET_WIDTH bits zeroed.
- MEM_LAT, 4: cycles from mem_rd_en/mem_wr_en assertion to data valid or write done; legal range 1..15.
- CNT_WIDTH, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_rw  in  1  1 = write, 0 = read
- cpu_req_addr  in  PA_WIDTH  request address
- cpu_req_ready  out  1  controller accepts the request this cycle
- cpu_resp_valid  out  1  one-cycle pulse: request retired
- arr_addr  out  PA_WIDTH  address presented to the cache array
- arr_lookup  out  1  array tag compare strobe
- tag_hit  in  1  array: valid and tag match, combinational on arr_addr
- victim_dirty  in  1  array: indexed line valid and dirty
- victim_tag_addr  in  PA_WIDTH  array: block address of the indexed line
- arr_rd_en  out  1  array word read (read hit)
- arr_wr_en  out  1  array word write; array sets the dirty bit
- arr_fill_en  out  1  load mem_rd_blk into the line; set valid, clear dirty
- mem_addr  out  PA_WIDTH  block-aligned memory address
- mem_rd_en  out  1  memory block read, level, held for MEM_LAT cycles
- mem_wr_en  out  1  memory block write, level, held for MEM_LAT cycles
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, latency counter 0, latched address 0.
- Reset has priority over everything and aborts any in-flight mem access. No fill or write-back completes after reset.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL, RESP.
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch addr and rw, then go to COMPARE.
- COMPARE:
  - arr_lookup = 1, arr_addr = latched addr.
  - tag_hit: read asserts arr_rd_en, write asserts arr_wr_en, same cycle; go to RESP.
  - miss with victim_dirty: go to WRITEBACK.
  - miss with clean victim: go to ALLOCATE.
- WRITEBACK:
  - mem_addr = victim_tag_addr, block-aligned.
  - mem_wr_en = 1 for exactly MEM_LAT cycles, counted by the latency counter.
  - Then go to ALLOCATE.
- ALLOCATE:
  - mem_addr = latched addr, block-aligned.
  - mem_rd_en = 1 for MEM_LAT cycles, then go to FILL.
- FILL:
  - arr_fill_en = 1 for one cycle.
  - Then return to COMPARE, which now hits and performs the read or write.
- RESP:
  - cpu_resp_valid = 1 for one cycle, then go to IDLE.
  - cpu_req_ready stays 0, so back-to-back requests leave a one-cycle gap.
- Latency:
  - Hit = 3 cycles from accept to resp.
  - Clean miss = 3 + MEM_LAT + 2.
  - Dirty miss = clean miss + MEM_LAT.
- Counter:
  - Loaded with MEM_LAT-1 on entry to WRITEBACK or ALLOCATE; decrements; state exits at 0.
  - MEM_LAT = 1 gives a single-cycle access.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- cpu_req_valid while busy is ignored; the requester must hold the request until cpu_req_ready.
- Address bits below OFFSET_WIDTH are forced to 0 on mem_addr in every state.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hits, stat_misses and stat_writebacks, each CNT_WIDTH bits.
  - Each increments on the first COMPARE of a request, or on WRITEBACK entry.
  - The post-fill COMPARE is not counted.
  - Counters saturate at all-ones and are cleared by rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cache_pkg holds:
  - PA_WIDTH, OFFSET_WIDTH and BLK_WIDTH constants;
  - enum cache_state_t {IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL, RESP};
  - a block-align function.
- One natural sub-module, mem_lat_cnt: a loadable down-counter with a zero flag, reused for both memory phases.

Test Plan:
- Reset then read 0x0000_0040 with tag_hit=1: arr_rd_en in cycle 2, cpu_resp_valid in cycle 3, no mem activity.
- Read 0x0000_1230 with tag_hit=0, victim_dirty=0, MEM_LAT=4:
  - mem_addr=0x0000_1230 and mem_rd_en high for 4 cycles;
  - arr_fill_en pulse;
  - hit COMPARE; resp at cycle 9.
- Write 0x0000_2000, miss, dirty victim 0x0000_7000:
  - mem_wr_en with mem_addr=0x0000_7000 for 4 cycles;
  - then mem_rd_en at 0x0000_2000 for 4 cycles;
  - fill, then arr_wr_en; resp at cycle 13.
- rst asserted in the 2nd ALLOCATE cycle: next cycle all outputs 0, state IDLE, cpu_req_ready=1, no arr_fill_en ever.
- Two requests held back-to-back, both hits: second accepted the cycle after the first cpu_resp_valid. cpu_req_valid while busy causes no extra lookups.
- CACHE_STATS_EN defined, sequence hit/miss-clean/miss-dirty: stat_hits=1, stat_misses=2, stat_writebacks=1.
